// File: rtl/detect_count_controller_pkg.sv
// Shared definitions for the detect/count sequencer: state encoding and default widths.
package detect_count_controller_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_EVT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COUNT   = 3'd2,
    RELEASE = 3'd3
  } state_t;

endpackage

// File: rtl/detect_count_controller_load_dncounter.sv
// Loadable down-counter that parks at zero instead of wrapping.
module load_dncounter
  import detect_count_controller_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);

  localparam logic [W-1:0] ONE_C = W'(1'b1);

  logic [W-1:0] q_r;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (ld) begin
      q_r <= d;
    end else if (dec && (q_r != '0)) begin
      q_r <= q_r - ONE_C;
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign zero = (q_r == '0);

endmodule

// File: rtl/detect_count_controller.sv
// Sequencer behind the pattern detector: holds for a programmable count after a match,
// then strobes the detector enable to release it, tallying serviced detections.
module detect_count_controller
  import detect_count_controller_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int EVT_W = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_w,
  input  logic [CNT_W-1:0] cnt_init,
  input  logic             clr_evt,
  output logic             det_en,
  output logic [CNT_W-1:0] cnt_val,
  output logic             busy,
  output logic             done,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [EVT_W-1:0] EVT_ONE_C = EVT_W'(1'b1);
  localparam logic [EVT_W-1:0] EVT_MAX_C = '1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ld_s;
  logic             dec_s;
  logic             inc_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_q_s;
  logic             det_en_r;
  logic             busy_r;
  logic [EVT_W-1:0] evt_r;

  load_dncounter #(.W(CNT_W)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld_s),
    .dec  (dec_s),
    .d    (cnt_init),
    .q    (cnt_q_s),
    .zero (cnt_zero_s)
  );

  // Next-state and counter control decode.
  always_comb begin
    state_nxt_s = IDLE;
    ld_s        = 1'b0;
    dec_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (det_w) begin
          state_nxt_s = LOAD;
          inc_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        ld_s        = 1'b1;
        state_nxt_s = COUNT;
      end
      COUNT: begin
        if (cnt_zero_s) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = COUNT;
          dec_s       = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; Moore outputs are registered from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      det_en_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      det_en_r <= (state_nxt_s == RELEASE);
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

  // Saturating detection tally; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_r <= '0;
    end else if (clr_evt) begin
      evt_r <= '0;
    end else if (inc_s && (evt_r != EVT_MAX_C)) begin
      evt_r <= evt_r + EVT_ONE_C;
    end else begin
      evt_r <= evt_r;
    end
  end

  assign det_en  = det_en_r;
  assign done    = det_en_r;
  assign busy    = busy_r;
  assign cnt_val = cnt_q_s;
  assign evt_cnt = evt_r;

endmodule

// File: tb/tb_detect_count_controller.sv
// Directed bench for detect_count_controller: vector table plus hand-written corner sequences.
module tb_detect_count_controller;

  logic       clk;
  logic       rst;
  logic       det_w;
  logic       det_w_drv;
  logic [3:0] cnt_init;
  logic       clr_evt;
  logic       use_det;
  logic       din;

  logic       det_en, done, busy;
  logic [3:0] cnt_val;
  logic [7:0] evt_cnt;

  logic       det_en2, done2, busy2;
  logic [3:0] cnt_val2;
  logic [1:0] evt_cnt2;

  logic       det_flag;
  logic [2:0] det_run;

  int tests_run = 0;
  int tests_failed = 0;

  detect_count_controller dut (
    .clk(clk), .rst(rst), .det_w(det_w), .cnt_init(cnt_init), .clr_evt(clr_evt),
    .det_en(det_en), .cnt_val(cnt_val), .busy(busy), .done(done), .evt_cnt(evt_cnt)
  );

  detect_count_controller #(.CNT_W(4), .EVT_W(2)) dut2 (
    .clk(clk), .rst(rst), .det_w(det_w), .cnt_init(cnt_init), .clr_evt(clr_evt),
    .det_en(det_en2), .cnt_val(cnt_val2), .busy(busy2), .done(done2), .evt_cnt(evt_cnt2)
  );

  assign det_w = use_det ? det_flag : det_w_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference detector: sticky flag after five consecutive ones, released by det_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_flag <= 1'b0;
      det_run  <= 3'd0;
    end else if (det_en) begin
      det_flag <= 1'b0;
      det_run  <= 3'd0;
    end else if (det_flag) begin
      det_flag <= 1'b1;
    end else if (din) begin
      if (det_run == 3'd4) begin
        det_flag <= 1'b1;
        det_run  <= 3'd0;
      end else begin
        det_run <= det_run + 3'd1;
      end
    end else begin
      det_run <= 3'd0;
    end
  end

  typedef struct {
    logic       det;
    logic [3:0] init;
    logic       clr;
    logic       en;
    logic [3:0] cnt;
    logic       bsy;
    logic [7:0] evt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic d, logic [3:0] i, logic c, logic e, logic [3:0] n,
                              logic b, logic [7:0] v);
    vec_t r;
    r.det = d; r.init = i; r.clr = c; r.en = e; r.cnt = n; r.bsy = b; r.evt = v;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rel_k, cnt_cycles, pulses, saw_det;
  int exp2[5] = '{1, 2, 3, 3, 3};
  int stream[7] = '{0, 1, 1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1; det_w_drv = 1'b0; cnt_init = 4'd0; clr_evt = 1'b0; use_det = 1'b0; din = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_det_en", det_en, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt_val", cnt_val, 0);
    chk("reset_evt_cnt", evt_cnt, 0);
    step();
    step();
    rst = 1'b0;

    // det, init, clr -> det_en, cnt_val, busy, evt_cnt after the following edge
    vecs.push_back(mk(1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd2, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd1, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 4'd0, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'd2));
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'd2));
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 8'd2));
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd2));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd2));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b1, 8'd0));
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 4'd2, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 4'd1, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b1, 4'd0, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));

    foreach (vecs[i]) begin
      det_w_drv = vecs[i].det;
      cnt_init  = vecs[i].init;
      clr_evt   = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_det_en", i), det_en, vecs[i].en);
      chk($sformatf("vec%0d_done", i), done, vecs[i].en);
      chk($sformatf("vec%0d_cnt_val", i), cnt_val, vecs[i].cnt);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d_evt_cnt", i), evt_cnt, vecs[i].evt);
    end
    clr_evt = 1'b0;

    // Longest hold: cnt_init=15 gives 16 COUNT cycles and RELEASE at t+18.
    det_w_drv = 1'b1; cnt_init = 4'd15;
    rel_k = 0; cnt_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 2) chk("max_first_cnt", cnt_val, 15);
      if (k == 17) chk("max_last_cnt", cnt_val, 0);
      if (det_en) begin
        rel_k = k;
        break;
      end
      if (k >= 2 && busy) cnt_cycles++;
    end
    chk("max_release_cycle", rel_k, 18);
    chk("max_count_cycles", cnt_cycles, 16);
    det_w_drv = 1'b0;
    step();
    chk("max_back_idle", busy, 0);

    // Reset in the middle of COUNT, with det_w still high afterwards.
    det_w_drv = 1'b1; cnt_init = 4'd4;
    step(); step(); step(); step();
    chk("rst_pre_cnt", cnt_val, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", cnt_val, 0);
    chk("rst_mid_evt", evt_cnt, 0);
    chk("rst_mid_det_en", det_en, 0);
    #1 rst = 1'b0;
    step();
    chk("rst_restart_busy", busy, 1);
    chk("rst_restart_evt", evt_cnt, 1);
    chk("rst_restart_cnt", cnt_val, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (det_en) begin
        pulses++;
        det_w_drv = 1'b0;
      end
    end
    chk("rst_restart_pulses", pulses, 1);

    // Saturation on a 2-bit tally, wide tally alongside.
    clr_evt = 1'b1;
    step();
    clr_evt = 1'b0;
    cnt_init = 4'd0;
    for (int i = 0; i < 5; i++) begin
      det_w_drv = 1'b1;
      step();
      chk($sformatf("sat%0d_evt2", i), evt_cnt2, exp2[i]);
      chk($sformatf("sat%0d_evt8", i), evt_cnt, i + 1);
      step(); step();
      det_w_drv = 1'b0;
      step();
    end

    // Closed loop with the reference detector, two identical streams.
    clr_evt = 1'b1;
    step();
    clr_evt = 1'b0;
    use_det = 1'b1; cnt_init = 4'd2;
    for (int rep = 0; rep < 2; rep++) begin
      pulses = 0; saw_det = 0;
      for (int k = 0; k < 17; k++) begin
        din = (k < 7) ? stream[k][0] : 1'b0;
        step();
        if (det_en) pulses++;
        if (det_w) saw_det = 1;
      end
      chk($sformatf("loop%0d_det_w_seen", rep), saw_det, 1);
      chk($sformatf("loop%0d_pulses", rep), pulses, 1);
      chk($sformatf("loop%0d_det_flag", rep), det_flag, 0);
      chk($sformatf("loop%0d_det_run", rep), det_run, 0);
      chk($sformatf("loop%0d_evt", rep), evt_cnt, rep + 1);
      chk($sformatf("loop%0d_idle", rep), busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
